// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the PWM duty-cycle capture
//               block (capture FSM states, default widths, sync depth helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } cap_state_t;

    localparam int PWM_CNT_W_DEF = 16;
    localparam int PWM_MIN_SYNC  = 2;

    // Synchronizer depth actually built: never fewer than the minimum.
    function automatic int sync_depth(input int stages);
        return (stages < PWM_MIN_SYNC) ? PWM_MIN_SYNC : stages;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_in_sync.sv
// ============================================================================
// Module      : pwm_in_sync
// Description : Brings the asynchronous PWM input into the MClk domain and
//               produces the clean level s plus a one-cycle rise strobe.
//               Optional glitch filter under PWM_CAPTURE_GLITCH_FILT_EN:
//               s only follows the synchronized input after three equal
//               consecutive samples (adds two cycles of latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_in_sync
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic MClk,
    input  logic RstN,
    input  logic PwmIn,
    output logic s,
    output logic rise
);

    localparam int c_stages = sync_depth(SYNC_STAGES);

    logic [c_stages-1:0] r_sync;
    logic                r_s_prev;
    logic                w_s;

    // Metastability chain: PwmIn enters at bit 0, the clean sample leaves the top bit.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_stages-2:0], PwmIn};
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILT_EN
    logic [1:0] r_hist;

    // Two previous synchronized samples; together with the current one they form the agreement window.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[0], r_sync[c_stages-1]};
        end
    end

    // Accept a new level only when three consecutive samples agree, otherwise keep the accepted one.
    assign w_s = ((r_sync[c_stages-1] == r_hist[0]) && (r_hist[0] == r_hist[1]))
                 ? r_sync[c_stages-1] : r_s_prev;
`else
    assign w_s = r_sync[c_stages-1];
`endif

    // Previous cycle's level: the edge-detect reference and, when filtering, the held level.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_s_prev <= 1'b0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    assign s    = w_s;
    assign rise = w_s & ~r_s_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_capture.sv
// ============================================================================
// Module      : pwm_duty_capture
// Description : Measures high time and period of a PWM input in MClk cycles
//               and publishes both once per period with a one-cycle strobe.
//               Flags a stuck line when no rising edge arrives before the
//               period counter saturates. Build option:
//               PWM_CAPTURE_GLITCH_FILT_EN (glitch filter in pwm_in_sync).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             MClk,
    input  logic             RstN,
    input  logic             PwmIn,
    input  logic             Enable,
    output logic [CNT_W-1:0] HighTime,
    output logic [CNT_W-1:0] Period,
    output logic             MeasValid,
    output logic             Stuck
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    cap_state_t       r_state;
    cap_state_t       w_state_next;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high_time;
    logic [CNT_W-1:0] r_period;
    logic             r_meas_valid;
    logic             r_stuck;
    logic             w_s;
    logic             w_rise;
    logic             w_clear;
    logic             w_load;
    logic             w_count;
    logic             w_publish;
    logic             w_stuck;
    logic             w_pcnt_max;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + 1'b1;
    endfunction

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .MClk  (MClk),
        .RstN  (RstN),
        .PwmIn (PwmIn),
        .s     (w_s),
        .rise  (w_rise)
    );

    assign w_pcnt_max = (r_pcnt == c_cnt_max);

    // Capture state register.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and datapath controls. A rise in LOW wins over saturation so an
    // exactly-max period still publishes; saturation otherwise drops back to ARM.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_count      = 1'b0;
        w_publish    = 1'b0;
        w_stuck      = 1'b0;
        if (!Enable) begin
            w_state_next = IDLE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = ARM;
                    w_clear      = 1'b1;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_next = HIGH;
                        w_load       = 1'b1;
                    end
                end
                HIGH: begin
                    if (w_pcnt_max) begin
                        w_state_next = ARM;
                        w_stuck      = 1'b1;
                        w_clear      = 1'b1;
                    end else begin
                        w_count = 1'b1;
                        if (!w_s) begin
                            w_state_next = LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_next = HIGH;
                        w_publish    = 1'b1;
                        w_load       = 1'b1;
                    end else if (w_pcnt_max) begin
                        w_state_next = ARM;
                        w_stuck      = 1'b1;
                        w_clear      = 1'b1;
                    end else begin
                        w_count = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    // Period and high-time counters: the rise cycle counts as 1, high time only grows in HIGH while s is set.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_clear) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_load) begin
            r_pcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_count) begin
            r_pcnt <= sat_inc(r_pcnt);
            if ((r_state == HIGH) && w_s) begin
                r_hcnt <= sat_inc(r_hcnt);
            end
        end
    end

    // Result registers, valid strobe and sticky stuck flag; results hold while disabled.
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_high_time  <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_valid <= w_publish;
            if (w_publish) begin
                r_high_time <= r_hcnt;
                r_period    <= r_pcnt;
                r_stuck     <= 1'b0;
            end else if (w_stuck) begin
                r_stuck     <= 1'b1;
            end
        end
    end

    assign HighTime  = r_high_time;
    assign Period    = r_period;
    assign MeasValid = r_meas_valid;
    assign Stuck     = r_stuck;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
// ============================================================================
// Module      : tb_pwm_duty_capture
// Description : Scoreboard bench for pwm_duty_capture. The stimulus side
//               drives whole PWM periods and, from the period lengths alone,
//               queues the result each completed period must produce; a
//               monitor pops and compares on every MeasValid. Honours
//               PWM_CAPTURE_GLITCH_FILT_EN (latency, minimum pulse width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_capture;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
`ifdef PWM_CAPTURE_GLITCH_FILT_EN
    localparam int FILT_LAT = 2;
    localparam int MIN_W    = 3;
`else
    localparam int FILT_LAT = 0;
    localparam int MIN_W    = 1;
`endif
    localparam int LAT    = SYNC_STAGES + 1 + FILT_LAT;
    localparam int MAXCNT = (1 << CNT_W) - 1;

    typedef struct {
        int h;
        int p;
        int at;
    } exp_t;

    logic             MClk   = 1'b0;
    logic             RstN   = 1'b0;
    logic             PwmIn  = 1'b0;
    logic             Enable = 1'b0;
    logic [CNT_W-1:0] HighTime;
    logic [CNT_W-1:0] Period;
    logic             MeasValid;
    logic             Stuck;

    bit   clk_run = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: enabled flag, the last complete period seen, last published pair.
    exp_t sb[$];
    exp_t mon_e;
    bit   en_m = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_h = 0;
    int   prev_p = 0;
    int   last_h = 0;
    int   last_p = 0;
    int   last_rise = 0;
    int   target = 0;

    pwm_duty_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .MClk      (MClk),
        .RstN      (RstN),
        .PwmIn     (PwmIn),
        .Enable    (Enable),
        .HighTime  (HighTime),
        .Period    (Period),
        .MeasValid (MeasValid),
        .Stuck     (Stuck)
    );

    // Gated clock so the reset test can stop MClk.
    always begin
        #5;
        if (clk_run) MClk = ~MClk;
    end

    // Rising-edge counter used to time expected results.
    always @(posedge MClk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MClk);
            #2;
        end
    endtask

    // A rise at the pin completes the previous period; it yields a result only
    // if that whole period was observed while enabled.
    task automatic note_rise(input int h, input int l);
        exp_t e;
        last_rise = cyc;
        if (en_m) begin
            if (have_prev) begin
                e.h  = prev_h;
                e.p  = prev_p;
                e.at = cyc + LAT;
                sb.push_back(e);
                last_h = prev_h;
                last_p = prev_p;
            end
            have_prev = 1'b1;
            prev_h    = h;
            prev_p    = h + l;
        end
    endtask

    task automatic pwm_period(input int h, input int l);
        PwmIn = 1'b1;
        note_rise(h, l);
        tick(h);
        PwmIn = 1'b0;
        tick(l);
    endtask

    // Monitor: every MeasValid must match the oldest queued expectation.
    always @(negedge MClk) begin
        if (RstN && MeasValid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_meas: got HighTime=%0d Period=%0d at cycle %0d, expected no result",
                         HighTime, Period, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("meas_hightime", HighTime, mon_e.h);
                check("meas_period", Period, mon_e.p);
                check("meas_latency_cycle", cyc, mon_e.at);
                check("meas_stuck_clear", Stuck, 0);
                check("meas_high_le_period", (HighTime <= Period), 1);
            end
        end
    end

    // Hard time limit in case the run wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        RstN = 1'b0;
        tick(3);
        check("reset_hightime", HighTime, 0);
        check("reset_period", Period, 0);
        check("reset_measvalid", MeasValid, 0);
        check("reset_stuck", Stuck, 0);
        RstN = 1'b1;
        tick(2);
        Enable = 1'b1;
        en_m = 1'b1;
        have_prev = 1'b0;
        tick(4);

        // Steady 10/30, then a duty step to 25/15, then the narrowest pulse
        repeat (5) pwm_period(10, 30);
        repeat (3) pwm_period(25, 15);
        pwm_period(MIN_W, 20);
        pwm_period(20, MIN_W);
        pwm_period(MIN_W, MIN_W);
        pwm_period(10, 30);

        // Randomized short and long periods
        repeat (60) pwm_period($urandom_range(40, MIN_W), $urandom_range(40, MIN_W));
        repeat (5) pwm_period($urandom_range(600, 50), $urandom_range(600, 50));

        // Enable dropped mid-LOW: results hold, nothing published while disabled
        pwm_period(10, 10);
        Enable = 1'b0;
        en_m = 1'b0;
        have_prev = 1'b0;
        tick(20);
        check("disable_hold_hightime", HighTime, last_h);
        check("disable_hold_period", Period, last_p);
        repeat (2) pwm_period(17, 23);
        check("disabled_hold_hightime", HighTime, last_h);
        check("disabled_hold_period", Period, last_p);

        // Re-enable while the line is high: the partial period is not measured
        PwmIn = 1'b1;
        note_rise(0, 0);
        tick(6);
        Enable = 1'b1;
        en_m = 1'b1;
        have_prev = 1'b0;
        tick(5);
        PwmIn = 1'b0;
        tick(30);
        repeat (4) pwm_period(10, 30);

        // Line held low: Stuck exactly when the period counter saturates
        target = last_rise + LAT + MAXCNT;
        do @(negedge MClk); while (cyc < target - 1);
        check("stuck_before_saturation", Stuck, 0);
        @(negedge MClk);
        check("stuck_at_saturation", Stuck, 1);
        have_prev = 1'b0;
        @(posedge MClk);
        #2;
        tick(50);
        check("stuck_sticky", Stuck, 1);
        pwm_period(10, 30);
        check("stuck_after_first_rise", Stuck, 1);
        pwm_period(10, 30);
        check("stuck_cleared", Stuck, 0);
        check("stuck_recover_hightime", HighTime, 10);
        repeat (2) pwm_period(10, 30);

        // Asynchronous reset mid-HIGH with MClk stopped
        PwmIn = 1'b1;
        note_rise(10, 30);
        tick(LAT + 3);
        check("pre_reset_hightime", HighTime, last_h);
        clk_run = 1'b0;
        #20;
        RstN = 1'b0;
        #1;
        check("async_reset_hightime", HighTime, 0);
        check("async_reset_period", Period, 0);
        check("async_reset_measvalid", MeasValid, 0);
        check("async_reset_stuck", Stuck, 0);
        last_h = 0;
        last_p = 0;
        have_prev = 1'b0;
        PwmIn = 1'b0;
        #10;
        RstN = 1'b1;
        #10;
        clk_run = 1'b1;
        @(posedge MClk);
        #2;
        tick(4);
        repeat (4) pwm_period(10, 30);

        tick(60);
        check("pending_results", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
